alu_op_sequencer: RTL and testbench

- Synthesizable multi-cycle controller that executes one 4-bit-opcode ALU or move instruction.
- Sequences the 4x8 register file (select/enable/read-write/write-data) and the 8-bit ALU (enable/mode/operands).
- Replaces hand-timed stimulus with a clocked FSM and a start/busy/done handshake.
- Sits between the instruction decode path and the registers/alu pair.

---
 rtl/alu_op_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer for one ALU or move instruction over a 4-entry register file
// and a registered 8-bit ALU, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; latches instruction fields on accept
// RDA   | read first source (rs for MR, rd otherwise)
// RDB   | capture first operand, read rs (register-form ALU only)
// OPND  | capture remaining operand(s)
// ALU   | one-cycle alu_en pulse with mode and operands
// WB    | write result back, load flags for ALU ops
// DONE  | one-cycle done pulse, illegal qualifies it
module alu_op_sequencer #(
  parameter int DW  = 8,
  parameter int RSW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [3:0]     opcode,
  input  logic [RSW-1:0] rd,
  input  logic [RSW-1:0] rs,
  input  logic [DW-1:0]  imm,
  input  logic [DW-1:0]  reg_rdata,
  input  logic [DW-1:0]  alu_result,
  input  logic           alu_zero,
  input  logic           alu_carry,
  output logic [RSW-1:0] reg_sel,
  output logic           reg_en,
  output logic           reg_rw,
  output logic [DW-1:0]  reg_wdata,
  output logic           alu_en,
  output logic [2:0]     alu_mode,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic           busy,
  output logic           done,
  output logic           illegal,
  output logic           zero_flag,
  output logic           carry_flag
);

  typedef enum logic [2:0] {
    S_IDLE, S_RDA, S_RDB, S_OPND, S_ALU, S_WB, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     op_q;
  logic [RSW-1:0] rd_q, rs_q;
  logic [DW-1:0]  imm_q, a_q, b_q;
  logic           zero_q, carry_q;

  function automatic logic [2:0] mode_of(input logic [3:0] op);
    case (op)
      4'b0100, 4'b1100: mode_of = 3'b000;
      4'b0101, 4'b1101: mode_of = 3'b001;
      4'b0110, 4'b1110: mode_of = 3'b100;
      4'b1000, 4'b1001: mode_of = 3'b101;
      4'b1010, 4'b1011: mode_of = 3'b110;
      4'b0111, 4'b1111: mode_of = 3'b111;
      default:          mode_of = 3'b000;
    endcase
  endfunction

  // Opcodes 0100..1111 are all ALU ops; 11xx plus 1001/1011 take the immediate.
  logic op_alu, op_imm, op_cmp, op_mi, op_mr, op_ill;
  logic in_alu, in_mi, in_mr;

  assign op_alu = op_q[3] | op_q[2];
  assign op_imm = op_q[3] & (op_q[2] | op_q[0]);
  assign op_cmp = (op_q[2:0] == 3'b111);
  assign op_mi  = (op_q == 4'b0010);
  assign op_mr  = (op_q == 4'b0011);
  assign op_ill = (op_q[3:1] == 3'b000);

  assign in_alu = opcode[3] | opcode[2];
  assign in_mi  = (opcode == 4'b0010);
  assign in_mr  = (opcode == 4'b0011);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q  <= opcode;
            rd_q  <= rd;
            rs_q  <= rs;
            imm_q <= imm;
          end
        end
        S_RDB: a_q <= reg_rdata;
        S_OPND: begin
          if (op_mr) begin
            a_q <= reg_rdata;
          end else if (op_imm) begin
            a_q <= reg_rdata;
            b_q <= imm_q;
          end else begin
            b_q <= reg_rdata;
          end
        end
        S_WB: begin
          if (op_alu) begin
            zero_q  <= alu_zero;
            carry_q <= alu_carry;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    reg_sel   = '0;
    reg_en    = 1'b0;
    reg_rw    = 1'b0;
    reg_wdata = '0;
    alu_en    = 1'b0;
    alu_mode  = 3'b000;
    alu_a     = '0;
    alu_b     = '0;
    done      = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (in_alu || in_mr) state_d = S_RDA;
          else if (in_mi)      state_d = S_WB;
          else                 state_d = S_DONE;
        end
      end
      S_RDA: begin
        reg_en  = 1'b1;
        reg_rw  = 1'b1;
        reg_sel = op_mr ? rs_q : rd_q;
        state_d = (op_alu && !op_imm) ? S_RDB : S_OPND;
      end
      S_RDB: begin
        reg_en  = 1'b1;
        reg_rw  = 1'b1;
        reg_sel = rs_q;
        state_d = S_OPND;
      end
      S_OPND: state_d = op_mr ? S_WB : S_ALU;
      S_ALU: begin
        alu_en   = 1'b1;
        alu_mode = mode_of(op_q);
        alu_a    = a_q;
        alu_b    = b_q;
        state_d  = S_WB;
      end
      S_WB: begin
        if (op_alu) begin
          alu_a = a_q;
          alu_b = b_q;
          // compares only update flags
          if (!op_cmp) begin
            reg_en    = 1'b1;
            reg_sel   = rd_q;
            reg_wdata = alu_result;
          end
        end else begin
          reg_en    = 1'b1;
          reg_sel   = rd_q;
          reg_wdata = op_mi ? imm_q : a_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        illegal = op_ill;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: register file and ALU environment, per-cycle schedule model,
// directed instruction list with literal result checks.
module tb_alu_op_sequencer;
  localparam int DW  = 8;
  localparam int RSW = 2;
  localparam int K_IDLE = 0, K_REG = 1, K_IMM = 2, K_MR = 3, K_MI = 4, K_ILL = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [3:0]     opcode;
  logic [RSW-1:0] rd, rs;
  logic [DW-1:0]  imm;
  logic [DW-1:0]  reg_rdata = '0;
  logic [DW-1:0]  alu_result = '0;
  logic           alu_zero = 1'b0, alu_carry = 1'b0;
  logic [RSW-1:0] reg_sel;
  logic           reg_en, reg_rw;
  logic [DW-1:0]  reg_wdata;
  logic           alu_en;
  logic [2:0]     alu_mode;
  logic [DW-1:0]  alu_a, alu_b;
  logic           busy, done, illegal, zero_flag, carry_flag;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DW(DW), .RSW(RSW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .rd(rd), .rs(rs), .imm(imm),
    .reg_rdata(reg_rdata), .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .reg_sel(reg_sel), .reg_en(reg_en), .reg_rw(reg_rw), .reg_wdata(reg_wdata),
    .alu_en(alu_en), .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b),
    .busy(busy), .done(done), .illegal(illegal), .zero_flag(zero_flag), .carry_flag(carry_flag)
  );

  // {carry, zero, result}; carry is carry-out for add, borrow for subtract/compare
  function automatic logic [9:0] alu_fn(input logic [2:0] mode, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    c = 1'b0;
    case (mode)
      3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
      3'b001, 3'b111: begin r = a - b; c = (a < b); end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: r = 8'h00;
    endcase
    return {c, (r == 8'h00), r};
  endfunction

  function automatic logic [2:0] mode_tbl(input logic [3:0] op);
    case (op)
      4'b0100, 4'b1100: return 3'b000;
      4'b0101, 4'b1101: return 3'b001;
      4'b0110, 4'b1110: return 3'b100;
      4'b1000, 4'b1001: return 3'b101;
      4'b1010, 4'b1011: return 3'b110;
      4'b0111, 4'b1111: return 3'b111;
      default:          return 3'b000;
    endcase
  endfunction

  function automatic int kind_of(input logic [3:0] op);
    if (op inside {4'b1100, 4'b1101, 4'b1110, 4'b1001, 4'b1011, 4'b1111}) return K_IMM;
    if (op inside {4'b0100, 4'b0101, 4'b0110, 4'b1000, 4'b1010, 4'b0111}) return K_REG;
    if (op == 4'b0010) return K_MI;
    if (op == 4'b0011) return K_MR;
    return K_ILL;
  endfunction

  function automatic int len_of(input int kind);
    case (kind)
      K_REG:   return 6;
      K_IMM:   return 5;
      K_MR:    return 4;
      K_MI:    return 2;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // environment: register file with 1-cycle read, ALU with registered result
  logic [7:0] mem [4];
  logic [7:0] pre_val [4];
  logic       load = 1'b0;
  always @(posedge clk) begin
    if (load) mem <= pre_val;
    else if (reg_en && !reg_rw) mem[reg_sel] <= reg_wdata;
    if (reg_en && reg_rw) reg_rdata <= mem[reg_sel];
    if (alu_en) {alu_carry, alu_zero, alu_result} <= alu_fn(alu_mode, alu_a, alu_b);
  end

  // model state: current instruction and its cycle index k after the accepting edge
  logic [7:0] arch [4];
  int         m_kind = K_IDLE, m_len = 1, m_k = 0;
  logic [1:0] m_rd = '0, m_rs = '0;
  logic [7:0] m_a = '0, m_b = '0, m_res = '0, m_wd = '0;
  logic [2:0] m_mode = '0;
  logic       m_cmp = 1'b0, m_z = 1'b0, m_c = 1'b0;

  always @(negedge clk) begin
    logic       e_en, e_rw, e_alu, e_opnd;
    logic [1:0] e_sel;
    logic [7:0] e_wd;
    e_en = 1'b0; e_rw = 1'b0; e_sel = '0; e_wd = '0; e_alu = 1'b0; e_opnd = 1'b0;
    if (m_k > 0) begin
      case (m_kind)
        K_REG: begin
          if (m_k == 1) begin e_en = 1'b1; e_rw = 1'b1; e_sel = m_rd; end
          if (m_k == 2) begin e_en = 1'b1; e_rw = 1'b1; e_sel = m_rs; end
          e_alu  = (m_k == 4);
          e_opnd = (m_k == 4) || (m_k == 5);
          if (m_k == 5 && !m_cmp) begin e_en = 1'b1; e_sel = m_rd; e_wd = m_wd; end
        end
        K_IMM: begin
          if (m_k == 1) begin e_en = 1'b1; e_rw = 1'b1; e_sel = m_rd; end
          e_alu  = (m_k == 3);
          e_opnd = (m_k == 3) || (m_k == 4);
          if (m_k == 4 && !m_cmp) begin e_en = 1'b1; e_sel = m_rd; e_wd = m_wd; end
        end
        K_MR: begin
          if (m_k == 1) begin e_en = 1'b1; e_rw = 1'b1; e_sel = m_rs; end
          if (m_k == 3) begin e_en = 1'b1; e_sel = m_rd; e_wd = m_wd; end
        end
        K_MI: if (m_k == 1) begin e_en = 1'b1; e_sel = m_rd; e_wd = m_wd; end
        default: ;
      endcase
    end
    chk("reg_en", reg_en, e_en);
    if (e_en) begin
      chk("reg_rw", reg_rw, e_rw);
      chk("reg_sel", reg_sel, e_sel);
    end
    chk("reg_wdata", reg_wdata, e_wd);
    chk("alu_en", alu_en, e_alu);
    chk("alu_mode", alu_mode, e_alu ? m_mode : 3'b000);
    chk("alu_a", alu_a, e_opnd ? m_a : 8'h00);
    chk("alu_b", alu_b, e_opnd ? m_b : 8'h00);
    chk("busy", busy, (m_k > 0) && (m_k < m_len));
    chk("done", done, (m_k > 0) && (m_k == m_len));
    chk("illegal", illegal, (m_k > 0) && (m_k == m_len) && (m_kind == K_ILL));
    chk("zero_flag", zero_flag, m_z);
    chk("carry_flag", carry_flag, m_c);
  end

  // Issue one instruction from an idle cycle; poke pulses start while busy and in DONE.
  // abort_at > 0 pulls rst_n low in that cycle instead of finishing.
  task automatic issue(input logic [3:0] op, input logic [1:0] d, input logic [1:0] s,
                       input logic [7:0] im, input bit poke, input int abort_at);
    logic [9:0] r;
    m_kind = kind_of(op);
    m_len  = len_of(m_kind);
    m_rd   = d;
    m_rs   = s;
    m_mode = mode_tbl(op);
    m_cmp  = (op[2:0] == 3'b111);
    m_a    = arch[d];
    m_b    = (m_kind == K_IMM || m_kind == K_MI) ? im : arch[s];
    r      = alu_fn(m_mode, m_a, m_b);
    m_res  = r[7:0];
    m_wd   = (m_kind == K_MI) ? im : (m_kind == K_MR) ? arch[s] : m_res;
    start = 1'b1; opcode = op; rd = d; rs = s; imm = im;
    @(posedge clk); #1;
    start = 1'b0; opcode = 4'($urandom); rd = 2'($urandom); rs = 2'($urandom); imm = 8'($urandom);
    for (int k = 1; k <= m_len; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == abort_at) begin
        rst_n = 1'b0;
        m_k = 0; m_z = 1'b0; m_c = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      m_k = k;
      if (k == m_len && (m_kind == K_REG || m_kind == K_IMM)) begin
        m_z = r[8]; m_c = r[9];
      end
      start = poke && (k == 1 || k == m_len);
    end
    @(posedge clk); #1;
    start = 1'b0;
    m_k = 0;
    if (m_kind == K_MI || m_kind == K_MR || ((m_kind == K_REG || m_kind == K_IMM) && !m_cmp))
      arch[d] = m_wd;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; opcode = '0; rd = '0; rs = '0; imm = '0;
    pre_val[0] = 8'h29; pre_val[1] = 8'hFF; pre_val[2] = 8'h01; pre_val[3] = 8'h55;
    arch = pre_val;
    load = 1'b1;
    repeat (2) @(posedge clk);
    #1 load = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(4'b1100, 2'd0, 2'd0, 8'h07, 1'b0, 0);   // SMI
    chk("smi_r0", mem[0], 8'h30);
    chk("smi_zero", zero_flag, 1'b0);
    chk("smi_carry", carry_flag, 1'b0);
    issue(4'b0100, 2'd1, 2'd2, 8'h00, 1'b0, 0);   // SUM wraps
    chk("sum_r1", mem[1], 8'h00);
    chk("sum_zero", zero_flag, 1'b1);
    chk("sum_carry", carry_flag, 1'b1);
    issue(4'b1111, 2'd3, 2'd0, 8'h55, 1'b0, 0);   // CMI equal
    chk("cmi_r3", mem[3], 8'h55);
    chk("cmi_zero", zero_flag, 1'b1);
    issue(4'b0010, 2'd2, 2'd0, 8'hA5, 1'b1, 0);   // MI
    chk("mi_r2", mem[2], 8'hA5);
    chk("mi_zero_kept", zero_flag, 1'b1);
    issue(4'b0011, 2'd0, 2'd2, 8'h00, 1'b1, 0);   // MR
    chk("mr_r0", mem[0], 8'hA5);
    issue(4'b0000, 2'd1, 2'd1, 8'h33, 1'b1, 0);   // LD illegal
    chk("ld_r1", mem[1], 8'h00);
    issue(4'b0001, 2'd2, 2'd3, 8'h44, 1'b0, 0);   // ST illegal
    issue(4'b0101, 2'd0, 2'd3, 8'h00, 1'b0, 0);   // SB
    chk("sb_r0", mem[0], 8'h50);
    issue(4'b1101, 2'd1, 2'd0, 8'h01, 1'b0, 0);   // SBI borrow
    chk("sbi_r1", mem[1], 8'hFF);
    chk("sbi_carry", carry_flag, 1'b1);
    issue(4'b1110, 2'd2, 2'd0, 8'h0F, 1'b0, 0);   // ANI
    issue(4'b1000, 2'd3, 2'd2, 8'h00, 1'b0, 0);   // ORR
    issue(4'b1011, 2'd0, 2'd0, 8'hFF, 1'b0, 0);   // XRI
    chk("xri_r0", mem[0], 8'hAF);
    issue(4'b0111, 2'd0, 2'd3, 8'h00, 1'b0, 0);   // CM no write
    issue(4'b1010, 2'd2, 2'd2, 8'h00, 1'b0, 0);   // XRR rd==rs
    chk("xrr_r2", mem[2], 8'h00);
    issue(4'b1001, 2'd2, 2'd0, 8'h80, 1'b0, 0);   // ORI
    issue(4'b1100, 2'd3, 2'd0, 8'h01, 1'b0, 3);   // SMI aborted by reset in ALU
    chk("abort_r3", mem[3], 8'h55);
    issue(4'b1100, 2'd3, 2'd0, 8'h01, 1'b0, 0);   // SMI after reset
    chk("post_rst_r3", mem[3], 8'h56);
    for (int i = 0; i < 4; i++) chk($sformatf("final_r%0d", i), mem[i], arch[i]);
    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
